// File: rtl/dbus_master_if.sv
// Pipeline request/response handshake plus the address/control half of the external data bus.
// DDT is bidirectional, so it is a plain inout on the block rather than a member of this interface.
interface dbus_master_if #(
   parameter int unsigned BIT_WIDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [1:0]           req_size;
   logic                 req_signed;
   logic [BIT_WIDTH-1:0] req_addr;
   logic [BIT_WIDTH-1:0] req_wdata;
   logic                 resp_valid;
   logic                 resp_err;
   logic [BIT_WIDTH-1:0] resp_rdata;
   logic [BIT_WIDTH-1:0] DAD;
   logic                 MREQ;
   logic                 WRITE;
   logic [1:0]           SIZE;
   logic                 ACKD_n;

   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
      output req_ready, resp_valid, resp_err, resp_rdata, DAD, MREQ, WRITE, SIZE
   );

   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ACKD_n,
      input  req_ready, resp_valid, resp_err, resp_rdata, DAD, MREQ, WRITE, SIZE
   );
endinterface

// File: rtl/dbus_master.sv
// Data-bus initiator: one load/store at a time, alignment check, ack wait with optional
// timeout, and sign/zero-extended load return.
module dbus_master #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   dbus_master_if.master        bus,
   inout  wire  [BIT_WIDTH-1:0] DDT
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBus  = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [1:0] SzWord = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;

   localparam logic [CNT_W-1:0] CntLast = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [BIT_WIDTH-1:0] dad_q, dad_d;
   logic [1:0]           size_q, size_d;
   logic                 write_q, write_d;
   logic                 mreq_q, mreq_d;
   logic                 signed_q, signed_d;
   logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [BIT_WIDTH-1:0] rdata_q, rdata_d;

   logic                 misaligned;
   logic [BIT_WIDTH-1:0] store_data;
   logic [BIT_WIDTH-1:0] load_data;

   always_comb begin
      misaligned = ((bus.req_size == SzWord) && (bus.req_addr[1:0] != 2'b00)) ||
                   ((bus.req_size == SzHalf) && bus.req_addr[0]);
   end

   // Size 2'b11 falls into the byte lane along with 2'b10.
   always_comb begin
      case (bus.req_size)
         SzWord:  store_data = bus.req_wdata;
         SzHalf:  store_data = BIT_WIDTH'(bus.req_wdata[15:0]);
         default: store_data = BIT_WIDTH'(bus.req_wdata[7:0]);
      endcase
   end

   always_comb begin
      case (size_q)
         SzWord:  load_data = DDT;
         SzHalf:  load_data = signed_q ? {{(BIT_WIDTH-16){DDT[15]}}, DDT[15:0]}
                                       : BIT_WIDTH'(DDT[15:0]);
         default: load_data = signed_q ? {{(BIT_WIDTH-8){DDT[7]}}, DDT[7:0]}
                                       : BIT_WIDTH'(DDT[7:0]);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      dad_d    = dad_q;
      size_d   = size_q;
      write_d  = write_q;
      mreq_d   = mreq_q;
      signed_d = signed_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rdata_d  = rdata_q;

      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (misaligned) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = StResp;
               end else begin
                  dad_d    = bus.req_addr;
                  size_d   = bus.req_size;
                  write_d  = bus.req_write;
                  mreq_d   = 1'b1;
                  signed_d = bus.req_signed;
                  wdata_d  = store_data;
                  cnt_d    = '0;
                  state_d  = StBus;
               end
            end
         end
         StBus: begin
            if (!bus.ACKD_n) begin
               rdata_d = write_q ? '0 : load_data;
               err_d   = 1'b0;
               mreq_d  = 1'b0;
               write_d = 1'b0;
               state_d = StResp;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CntLast) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  mreq_d  = 1'b0;
                  write_d = 1'b0;
                  state_d = StResp;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Reset also abandons any access in flight without producing a response.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         dad_q    <= '0;
         size_q   <= 2'b00;
         write_q  <= 1'b0;
         mreq_q   <= 1'b0;
         signed_q <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         dad_q    <= dad_d;
         size_q   <= size_d;
         write_q  <= write_d;
         mreq_q   <= mreq_d;
         signed_q <= signed_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_err   = (state_q == StResp) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.DAD        = dad_q;
   assign bus.MREQ       = mreq_q;
   assign bus.WRITE      = write_q;
   assign bus.SIZE       = size_q;

   assign DDT = (mreq_q && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule
